pci_target_mem: RTL and testbench
=================================

// Module: pci_target_mem
// PURPOSE
//  Parametrised PCI target with a byte-enabled word memory behind it.
//  Single-edge (posedge clk) successor to the fixed 4-word, fixed-address target.
//  Adds: configurable base/depth, burst index wrap, programmable wait states, per-byte write enables.
//  Sits between the PCI bus model (AD tristate resolved at top level) and local debug logic.
// PARAMETERS
//  ADDR_BASE    32'h0000_0010  base byte address; decode hit when ad[31:AW+2]==ADDR_BASE[31:AW+2]
//  MEM_DEPTH    4              number of 32-bit words, power of two, 2..256; AW=$clog2(MEM_DEPTH)
//  WAIT_STATES  0              trdy_n high cycles inserted after every completed data phase, 0..7
// PORTS
//  clk       in   1   bus clock; all logic on rising edge
//  rst       in   1   synchronous, active-high reset
//  frame_n   in   1   PCI FRAME#, active low
//  irdy_n    in   1   PCI IRDY#, active low
//  cbe_n     in   4   command in address phase; byte enables (active low) in data phases
//  ad_in     in   32  AD bus as seen by target
//  ad_out    out  32  read data driven to AD
//  ad_oe     out  1   1 = top level drives ad_out onto AD
//  devsel_n  out  1   PCI DEVSEL#, active low
//  trdy_n    out  1   PCI TRDY#, active low
//  stop_n    out  1   PCI STOP#, active low (constant 1 unless PCI_TGT_DISCONNECT_EN)
//  dbg_idx   in   AW  debug word index
//  dbg_data  out  32  MEM[dbg_idx], combinational
// BEHAVIOUR
//  Reset: state IDLE; devsel_n=trdy_n=stop_n=1; ad_oe=0; ad_out=0; index=0; all MEM words=0.
//  Commands: 4'b0010 read, 4'b0011 write; all other codes -> not claimed.
//  IDLE: on edge with frame_n=0, latch ad_in and cbe_n (address phase).
//    Hit and supported cmd -> index=ad_in[AW+1:2]; go to WR or RD_TA. Else -> SKIP.
//  SKIP: outputs idle; return to IDLE on edge with frame_n=1 and irdy_n=1.
//  Write: devsel_n=0 and trdy_n=0 on the cycle after address phase (fast decode).
//  Read: devsel_n=0 on the cycle after address phase, with ad_oe=1 (turnaround).
//    RD_TA -> RD: trdy_n=0 one cycle later; ad_out=MEM[index] valid while trdy_n=0.
//  Transfer: edge with irdy_n=0 and trdy_n=0.
//    Write stores ad_in bytes whose cbe_n bit is 0; cbe_n=4'hF stores nothing, still counts.
//    Read ignores byte enables and returns the full word.
//    Each transfer: index=index+1, wrapping MEM_DEPTH-1 -> 0.
//  Wait states: after a transfer trdy_n=1 for WAIT_STATES cycles, then 0 again.
//    irdy_n=1 with trdy_n=0: hold trdy_n and ad_out; no transfer.
//  Last transfer: edge with frame_n=1 and transfer -> next cycle devsel_n=trdy_n=1, ad_oe=0, IDLE.
//  frame_n=1 and irdy_n=1 while claimed (master abort) -> IDLE next cycle, no memory write.
//  rst mid-transaction: immediate return to reset values; partial burst words already written are lost.
//  Read after write to the same index in consecutive transactions returns the new data.
// CONFIGURATION
//  PCI_TGT_DISCONNECT_EN defined: a transfer at index MEM_DEPTH-1 with frame_n=0 asserts stop_n=0.
//    stop_n stays 0 and trdy_n=1 until frame_n=1; then stop_n, devsel_n=1 and IDLE (disconnect with data).
//    No wrap occurs.
//  Not defined: stop_n tied 1; index wraps to 0 and the burst continues.
// STRUCTURE
//  Package pci_pkg:
//    localparams PCI_CMD_READ=4'b0010, PCI_CMD_WRITE=4'b0011
//    state enum {IDLE, SKIP, WR, RD_TA, RD, DISC}
//    wait-counter width constant
//  Sub-module pci_tgt_ram: MEM_DEPTH x 32 array.
//    Ports: clk, rst, we, byte-enable[3:0], wr_idx, wr_data, rd_idx, rd_data, dbg_idx, dbg_data.
//    Synchronous clear on rst.
//  Top module owns the FSM, index, and wait counter.
// TESTING
//  1 Write burst to 0x10, 4 words 1001..1004, cbe_n=0; then read burst.
//    -> reads return 1001,1002,1003,1004; devsel_n low 1 cycle after address.
//  2 Write 0xAABBCCDD, then write 0x11223344 with cbe_n=4'b1010 to index 0.
//    -> MEM[0]=0xAA22CC44; cbe_n=4'hF write leaves the word unchanged.
//  3 Address 0x20 with MEM_DEPTH=4.
//    -> devsel_n, trdy_n, ad_oe stay inactive through the transaction; then next hit to 0x10 is claimed.
//  4 WAIT_STATES=2, 3-word read -> trdy_n pattern 0,1,1,0,1,1,0.
//    Also: irdy_n=1 for one cycle mid-burst holds ad_out.
//  5 Write burst of 6 words from 0x10.
//    Without macro: MEM[0..1] overwritten by words 5,6.
//    With PCI_TGT_DISCONNECT_EN: stop_n=0 after word 4; MEM unchanged by 5,6.
//  6 rst pulsed during read data phase -> next cycle all outputs idle, MEM all 0, state IDLE.

Source files
------------

// File: rtl/pci_target_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pci_pkg : command codes, FSM states and wait-counter width shared by  |
// |           the PCI target and its word memory.                         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package pci_pkg;

  localparam logic [3:0] PCI_CMD_READ  = 4'b0010;
  localparam logic [3:0] PCI_CMD_WRITE = 4'b0011;

  // Wide enough for the largest programmable wait-state count (7).
  localparam int WAIT_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SKIP  = 3'd1,
    WR    = 3'd2,
    RD_TA = 3'd3,
    RD    = 3'd4,
    DISC  = 3'd5
  } pci_state_e;

endpackage : pci_pkg
`default_nettype wire

// File: rtl/pci_target_mem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pci_tgt_ram : MEM_DEPTH x 32 word memory with per-byte write enables, |
// |               synchronous clear, async read port and debug port.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pci_tgt_ram #(
  parameter int MEM_DEPTH = 4,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [31:0]   rd_data_o,
  input  logic [AW-1:0] dbg_idx_i,
  output logic [31:0]   dbg_data_o
);

  logic [31:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        mem_q[w] <= 32'h0;
      end
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  assign rd_data_o  = mem_q[rd_idx_i];
  assign dbg_data_o = mem_q[dbg_idx_i];

endmodule : pci_tgt_ram
`default_nettype wire

// File: rtl/pci_target_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pci_target_mem : PCI target (read/write) fronting a byte-enabled word |
// |   memory; optional disconnect-at-end via PCI_TGT_DISCONNECT_EN.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pci_target_mem
  import pci_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0010,
  parameter int          MEM_DEPTH   = 4,
  parameter int          WAIT_STATES = 0,
  localparam int         AW          = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_n,
  input  logic          irdy_n,
  input  logic [3:0]    cbe_n,
  input  logic [31:0]   ad_in,
  output logic [31:0]   ad_out,
  output logic          ad_oe,
  output logic          devsel_n,
  output logic          trdy_n,
  output logic          stop_n,
  input  logic [AW-1:0] dbg_idx,
  output logic [31:0]   dbg_data
);

`ifdef PCI_TGT_DISCONNECT_EN
  localparam bit DISC_EN = 1'b1;
`else
  localparam bit DISC_EN = 1'b0;
`endif

  localparam logic [AW-1:0] LAST_IDX = AW'(MEM_DEPTH - 1);

  pci_state_e            state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d, idx_inc, rd_idx;
  logic [WAIT_CNT_W-1:0] wcnt_q, wcnt_d;
  logic                  devsel_q, devsel_d, trdy_q, trdy_d;
  logic                  stop_q, stop_d, oe_q, oe_d;
  logic [31:0]           ad_out_q, ad_out_d, rd_data;
  logic                  hit, xfer, bus_idle, ram_we;
  logic                  unused_ad_lsb;

  assign hit      = (ad_in[31:AW+2] == ADDR_BASE[31:AW+2]);
  assign idx_inc  = idx_q + AW'(1);
  assign xfer     = !irdy_n && !trdy_q && (state_q == WR || state_q == RD);
  assign bus_idle = frame_n && irdy_n;
  assign ram_we   = xfer && (state_q == WR);
  assign unused_ad_lsb = ^ad_in[1:0];

  // With no wait states the next read word must be presented on the same
  // edge as the transfer, so look one word ahead.
  assign rd_idx = (WAIT_STATES == 0 && state_q == RD) ? idx_inc : idx_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    devsel_d = devsel_q;
    trdy_d   = trdy_q;
    stop_d   = stop_q;
    oe_d     = oe_q;
    ad_out_d = ad_out_q;

    case (state_q)
      IDLE: begin
        if (!frame_n) begin
          if (hit && cbe_n == PCI_CMD_WRITE) begin
            state_d  = WR;
            idx_d    = ad_in[AW+1:2];
            devsel_d = 1'b0;
            trdy_d   = 1'b0;
          end else if (hit && cbe_n == PCI_CMD_READ) begin
            state_d  = RD_TA;
            idx_d    = ad_in[AW+1:2];
            devsel_d = 1'b0;
            oe_d     = 1'b1;
          end else begin
            state_d = SKIP;
          end
        end
      end

      SKIP: begin
        if (bus_idle) state_d = IDLE;
      end

      RD_TA: begin
        if (bus_idle) begin
          state_d = IDLE;
        end else begin
          state_d  = RD;
          trdy_d   = 1'b0;
          ad_out_d = rd_data;
        end
      end

      WR, RD: begin
        if (bus_idle) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (frame_n) begin
            state_d = IDLE;
          end else if (DISC_EN && idx_q == LAST_IDX) begin
            state_d = DISC;
            stop_d  = 1'b0;
            trdy_d  = 1'b1;
          end else begin
            idx_d = idx_inc;
            if (WAIT_STATES != 0) begin
              trdy_d = 1'b1;
              wcnt_d = WAIT_CNT_W'(WAIT_STATES);
            end else if (state_q == RD) begin
              ad_out_d = rd_data;
            end
          end
        end else if (trdy_q && wcnt_q != '0) begin
          wcnt_d = wcnt_q - WAIT_CNT_W'(1);
          if (wcnt_q == WAIT_CNT_W'(1)) begin
            trdy_d = 1'b0;
            if (state_q == RD) ad_out_d = rd_data;
          end
        end
      end

      DISC: begin
        if (frame_n) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Every path back to IDLE releases the bus in the same cycle.
    if (state_d == IDLE) begin
      idx_d    = idx_q;
      wcnt_d   = '0;
      devsel_d = 1'b1;
      trdy_d   = 1'b1;
      stop_d   = 1'b1;
      oe_d     = 1'b0;
      ad_out_d = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wcnt_q   <= '0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      oe_q     <= 1'b0;
      ad_out_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      devsel_q <= devsel_d;
      trdy_q   <= trdy_d;
      stop_q   <= stop_d;
      oe_q     <= oe_d;
      ad_out_q <= ad_out_d;
    end
  end

  pci_tgt_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .we_i       (ram_we),
    .be_i       (~cbe_n),
    .wr_idx_i   (idx_q),
    .wr_data_i  (ad_in),
    .rd_idx_i   (rd_idx),
    .rd_data_o  (rd_data),
    .dbg_idx_i  (dbg_idx),
    .dbg_data_o (dbg_data)
  );

  assign ad_out   = ad_out_q;
  assign ad_oe    = oe_q;
  assign devsel_n = devsel_q;
  assign trdy_n   = trdy_q;
  assign stop_n   = stop_q;

endmodule : pci_target_mem
`default_nettype wire

// File: tb/tb_pci_target_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pci_target_mem : directed bench for pci_target_mem; u_dut has no   |
// |   wait states, u_ws has two. Revision: 1.0                            |
// +----------------------------------------------------------------------+
module tb_pci_target_mem;

  logic        clk = 1'b0;
  logic        rst, frame_n, irdy_n;
  logic [3:0]  cbe_n;
  logic [31:0] ad_in;
  logic [1:0]  dbg_idx;

  logic [31:0] ad_out0, dbg0, ad_out1, dbg1;
  logic        oe0, devsel0, trdy0, stop0;
  logic        oe1, devsel1, trdy1, stop1;

  logic        sel;
  logic        trdy_s, devsel_s, stop_s, oe_s;
  logic [31:0] ad_out_s;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wdata [8];
  logic [3:0]  wbe   [8];
  logic [31:0] rdata [8];

  always #5 clk = ~clk;

  pci_target_mem #(.ADDR_BASE(32'h10), .MEM_DEPTH(4), .WAIT_STATES(0)) u_dut (
    .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .cbe_n(cbe_n),
    .ad_in(ad_in), .ad_out(ad_out0), .ad_oe(oe0), .devsel_n(devsel0),
    .trdy_n(trdy0), .stop_n(stop0), .dbg_idx(dbg_idx), .dbg_data(dbg0)
  );

  pci_target_mem #(.ADDR_BASE(32'h10), .MEM_DEPTH(4), .WAIT_STATES(2)) u_ws (
    .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .cbe_n(cbe_n),
    .ad_in(ad_in), .ad_out(ad_out1), .ad_oe(oe1), .devsel_n(devsel1),
    .trdy_n(trdy1), .stop_n(stop1), .dbg_idx(dbg_idx), .dbg_data(dbg1)
  );

  assign trdy_s   = sel ? trdy1   : trdy0;
  assign devsel_s = sel ? devsel1 : devsel0;
  assign stop_s   = sel ? stop1   : stop0;
  assign oe_s     = sel ? oe1     : oe0;
  assign ad_out_s = sel ? ad_out1 : ad_out0;

  task automatic bus_idle();
    frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'h0; ad_in = 32'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Master write burst of n words from wdata/wbe; stops early on STOP#.
  task automatic do_write(input logic [31:0] addr, input int n,
                          output logic dev1, output logic stopped);
    int t;
    stopped = 1'b0;
    frame_n = 1'b0; irdy_n = 1'b1; cbe_n = 4'b0011; ad_in = addr;
    @(negedge clk);
    dev1 = devsel_s;
    for (int i = 0; i < n; i++) begin
      ad_in = wdata[i]; cbe_n = wbe[i]; irdy_n = 1'b0; frame_n = (i == n - 1);
      t = 0;
      while (trdy_s !== 1'b0 && stop_s !== 1'b0 && t < 16) begin
        @(negedge clk);
        t++;
      end
      if (stop_s === 1'b0) begin
        stopped = 1'b1;
        break;
      end
      if (t >= 16) begin
        checks++; failures++;
        $display("FAIL write_timeout: word %0d trdy_n=%b required 0", i, trdy_s);
        break;
      end
      @(negedge clk);
    end
    bus_idle();
    @(negedge clk);
  endtask

  // Master read burst of n words into rdata; byte enables all off.
  task automatic do_read(input logic [31:0] addr, input int n,
                         output logic dev1, output logic oe1st);
    int t;
    frame_n = 1'b0; irdy_n = 1'b1; cbe_n = 4'b0010; ad_in = addr;
    @(negedge clk);
    dev1 = devsel_s; oe1st = oe_s;
    cbe_n = 4'hF; ad_in = 32'h0;
    for (int i = 0; i < n; i++) begin
      frame_n = (i == n - 1); irdy_n = 1'b0;
      t = 0;
      while (trdy_s !== 1'b0 && t < 16) begin
        @(negedge clk);
        t++;
      end
      if (t >= 16) begin
        checks++; failures++;
        $display("FAIL read_timeout: word %0d trdy_n=%b required 0", i, trdy_s);
        break;
      end
      rdata[i] = ad_out_s;
      @(negedge clk);
    end
    bus_idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({devsel0, trdy0, stop0, oe0} !== 4'b1110) begin
      failures++;
      $display("FAIL reset_ctrl: devsel/trdy/stop/oe=%b required 1110", {devsel0, trdy0, stop0, oe0});
    end
    checks++;
    if (ad_out0 !== 32'h0) begin
      failures++;
      $display("FAIL reset_ad_out: got %h required 00000000", ad_out0);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_idx = 2'(i); #1;
      checks++;
      if (dbg0 !== 32'h0) begin
        failures++;
        $display("FAIL reset_mem%0d: got %h required 00000000", i, dbg0);
      end
    end
  endtask

  task automatic test_burst();
    logic d1, o1, st;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'h1001 + 32'(i); wbe[i] = 4'h0;
    end
    do_write(32'h10, 4, d1, st);
    checks++;
    if (d1 !== 1'b0) begin
      failures++;
      $display("FAIL burst_wr_devsel: got %b required 0", d1);
    end
    do_read(32'h10, 4, d1, o1);
    checks++;
    if ({d1, o1} !== 2'b01) begin
      failures++;
      $display("FAIL burst_rd_devsel_oe: got %b required 01", {d1, o1});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdata[i] !== 32'h1001 + 32'(i)) begin
        failures++;
        $display("FAIL burst_rd%0d: got %h required %h", i, rdata[i], 32'h1001 + 32'(i));
      end
    end
  endtask

  task automatic test_byte_enables();
    logic d1, o1, st;
    apply_reset();
    dbg_idx = 2'd0;
    wdata[0] = 32'hAABB_CCDD; wbe[0] = 4'h0;
    do_write(32'h10, 1, d1, st);
    wdata[0] = 32'h1122_3344; wbe[0] = 4'b1010;
    do_write(32'h10, 1, d1, st);
    #1;
    checks++;
    if (dbg0 !== 32'hAA22_CC44) begin
      failures++;
      $display("FAIL byte_enable_merge: got %h required aa22cc44", dbg0);
    end
    wdata[0] = 32'hFFFF_FFFF; wbe[0] = 4'hF;
    do_write(32'h10, 1, d1, st);
    #1;
    checks++;
    if (dbg0 !== 32'hAA22_CC44) begin
      failures++;
      $display("FAIL byte_enable_none: got %h required aa22cc44", dbg0);
    end
    do_read(32'h10, 1, d1, o1);
    checks++;
    if (rdata[0] !== 32'hAA22_CC44) begin
      failures++;
      $display("FAIL byte_enable_read: got %h required aa22cc44", rdata[0]);
    end
  endtask

  task automatic test_no_claim();
    logic        d1, st;
    logic [31:0] addr_tab [2];
    logic [3:0]  cmd_tab  [2];
    addr_tab[0] = 32'h20; cmd_tab[0] = 4'b0011;
    addr_tab[1] = 32'h10; cmd_tab[1] = 4'b0110;
    apply_reset();
    for (int p = 0; p < 2; p++) begin
      frame_n = 1'b0; irdy_n = 1'b1; cbe_n = cmd_tab[p]; ad_in = addr_tab[p];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if ({devsel0, trdy0, oe0} !== 3'b110) begin
          failures++;
          $display("FAIL no_claim_p%0d_c%0d: devsel/trdy/oe=%b required 110", p, c, {devsel0, trdy0, oe0});
        end
        if (c == 0) begin
          frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'h0; ad_in = 32'hDEAD_BEEF;
        end else begin
          bus_idle();
        end
      end
    end
    wdata[0] = 32'h5A5A_0001; wbe[0] = 4'h0;
    do_write(32'h10, 1, d1, st);
    dbg_idx = 2'd0; #1;
    checks++;
    if ({d1, dbg0} !== {1'b0, 32'h5A5A_0001}) begin
      failures++;
      $display("FAIL claim_after_miss: devsel=%b mem0=%h required 0 5a5a0001", d1, dbg0);
    end
  endtask

  task automatic test_wait_states();
    logic       d1, st;
    logic [6:0] pat;
    pat = 7'b0110110;
    apply_reset();
    sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata[i] = 32'hA0A0_0000 + 32'(i); wbe[i] = 4'h0;
    end
    do_write(32'h10, 3, d1, st);
    frame_n = 1'b0; irdy_n = 1'b1; cbe_n = 4'b0010; ad_in = 32'h10;
    @(negedge clk);
    cbe_n = 4'h0; ad_in = 32'h0; irdy_n = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (trdy1 !== pat[6-c]) begin
        failures++;
        $display("FAIL ws_trdy_c%0d: got %b required %b", c, trdy1, pat[6-c]);
      end
      if (c % 3 == 0) begin
        checks++;
        if (ad_out1 !== 32'hA0A0_0000 + 32'(c / 3)) begin
          failures++;
          $display("FAIL ws_data_c%0d: got %h required %h", c, ad_out1, 32'hA0A0_0000 + 32'(c / 3));
        end
      end
      if (c == 6) frame_n = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({devsel1, trdy1, oe1} !== 3'b110) begin
      failures++;
      $display("FAIL ws_end: devsel/trdy/oe=%b required 110", {devsel1, trdy1, oe1});
    end
    bus_idle();
    @(negedge clk);
    // Single-word read with the master stalling one cycle.
    frame_n = 1'b0; cbe_n = 4'b0010; ad_in = 32'h18;
    @(negedge clk);
    cbe_n = 4'h0; ad_in = 32'h0; irdy_n = 1'b0;
    @(negedge clk);
    irdy_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({trdy1, ad_out1} !== {1'b0, 32'hA0A0_0002}) begin
      failures++;
      $display("FAIL ws_irdy_hold: trdy=%b data=%h required 0 a0a00002", trdy1, ad_out1);
    end
    frame_n = 1'b1; irdy_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({devsel1, trdy1, oe1} !== 3'b110) begin
      failures++;
      $display("FAIL ws_hold_end: devsel/trdy/oe=%b required 110", {devsel1, trdy1, oe1});
    end
    bus_idle();
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_wrap();
    logic        d1, st;
    logic [31:0] exp [4];
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      wdata[i] = 32'h5000_0001 + 32'(i); wbe[i] = 4'h0;
    end
`ifdef PCI_TGT_DISCONNECT_EN
    exp[0] = 32'h5000_0001; exp[1] = 32'h5000_0002;
    exp[2] = 32'h5000_0003; exp[3] = 32'h5000_0004;
`else
    exp[0] = 32'h5000_0005; exp[1] = 32'h5000_0006;
    exp[2] = 32'h5000_0003; exp[3] = 32'h5000_0004;
`endif
    do_write(32'h10, 6, d1, st);
    checks++;
`ifdef PCI_TGT_DISCONNECT_EN
    if (st !== 1'b1) begin
      failures++;
      $display("FAIL wrap_stop_seen: got %b required 1", st);
    end
`else
    if (st !== 1'b0) begin
      failures++;
      $display("FAIL wrap_stop_seen: got %b required 0", st);
    end
`endif
    checks++;
    if ({devsel0, trdy0, stop0} !== 3'b111) begin
      failures++;
      $display("FAIL wrap_end: devsel/trdy/stop=%b required 111", {devsel0, trdy0, stop0});
    end
    for (int i = 0; i < 4; i++) begin
      dbg_idx = 2'(i); #1;
      checks++;
      if (dbg0 !== exp[i]) begin
        failures++;
        $display("FAIL wrap_mem%0d: got %h required %h", i, dbg0, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic d1, st;
    apply_reset();
    wdata[0] = 32'h6000_0001; wdata[1] = 32'h6000_0002;
    wbe[0] = 4'h0; wbe[1] = 4'h0;
    do_write(32'h10, 2, d1, st);
    frame_n = 1'b0; irdy_n = 1'b1; cbe_n = 4'b0010; ad_in = 32'h10;
    @(negedge clk);
    cbe_n = 4'h0; ad_in = 32'h0; irdy_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({trdy0, ad_out0} !== {1'b0, 32'h6000_0001}) begin
      failures++;
      $display("FAIL midrst_pre: trdy=%b data=%h required 0 60000001", trdy0, ad_out0);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({devsel0, trdy0, stop0, oe0, ad_out0} !== {4'b1110, 32'h0}) begin
      failures++;
      $display("FAIL midrst_outputs: ctrl=%b data=%h required 1110 00000000",
               {devsel0, trdy0, stop0, oe0}, ad_out0);
    end
    for (int i = 0; i < 2; i++) begin
      dbg_idx = 2'(i); #1;
      checks++;
      if (dbg0 !== 32'h0) begin
        failures++;
        $display("FAIL midrst_mem%0d: got %h required 00000000", i, dbg0);
      end
    end
    rst = 1'b0;
    bus_idle();
    @(negedge clk);
    wdata[0] = 32'h7777_0001; wbe[0] = 4'h0;
    do_write(32'h14, 1, d1, st);
    dbg_idx = 2'd1; #1;
    checks++;
    if ({d1, dbg0} !== {1'b0, 32'h7777_0001}) begin
      failures++;
      $display("FAIL midrst_reclaim: devsel=%b mem1=%h required 0 77770001", d1, dbg0);
    end
  endtask

  initial begin
    sel = 1'b0;
    dbg_idx = 2'd0;
    test_reset();
    test_burst();
    test_byte_enables();
    test_no_claim();
    test_wait_states();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_pci_target_mem
`default_nettype wire
